// File: rtl/tpg_timing_ctrl.sv
// Timing control for the test-pattern generator: shadow/active timing set,
// commit validation, frame-aligned apply and start/stop sequencing.
module tpg_timing_ctrl #(
    parameter int H_BITS  = 12,
    parameter int V_BITS  = 12,
    parameter int FC_BITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [3:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    input  logic               cfg_commit,
    input  logic               start,
    input  logic               stop,
    input  logic               frame_end,
    output logic [H_BITS-1:0]  tHS_START,
    output logic [H_BITS-1:0]  tHS_END,
    output logic [H_BITS-1:0]  tHACT_START,
    output logic [H_BITS-1:0]  tHACT_END,
    output logic [H_BITS-1:0]  tH_END,
    output logic [V_BITS-1:0]  tVS_START,
    output logic [V_BITS-1:0]  tVS_END,
    output logic [V_BITS-1:0]  tVACT_START,
    output logic [V_BITS-1:0]  tVACT_END,
    output logic [V_BITS-1:0]  tV_END,
    output logic               tpg_en,
    output logic               cfg_busy,
    output logic               cfg_err,
    output logic               cfg_valid,
    output logic [FC_BITS-1:0] frame_cnt,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [H_BITS-1:0]  r_sh_h  [5];
    logic [V_BITS-1:0]  r_sh_v  [5];
    logic [H_BITS-1:0]  r_act_h [5];
    logic [V_BITS-1:0]  r_act_v [5];
    logic               r_busy;
    logic               r_err;
    logic               r_valid;
    logic [FC_BITS-1:0] r_frame_cnt;

    logic w_addr_ok, w_wr_en, w_wr_err;
    logic w_cfg_ok, w_commit, w_commit_ok, w_commit_bad;
    logic w_fe_active, w_load, w_start_err;
    logic w_unused_wdata;

    // Upper write-data bits beyond the timing width are intentionally dropped.
    assign w_unused_wdata = ^cfg_wdata;

    assign w_addr_ok = (cfg_addr < 4'd10);
    assign w_wr_en   = cfg_wr && w_addr_ok && !r_busy;
    assign w_wr_err  = cfg_wr && (!w_addr_ok || r_busy);

    assign w_cfg_ok = (r_sh_h[0] <  r_sh_h[1]) && (r_sh_h[1] <= r_sh_h[4]) &&
                      (r_sh_h[2] <  r_sh_h[3]) && (r_sh_h[3] <= r_sh_h[4]) &&
                      (r_sh_v[0] <  r_sh_v[1]) && (r_sh_v[1] <= r_sh_v[4]) &&
                      (r_sh_v[2] <  r_sh_v[3]) && (r_sh_v[3] <= r_sh_v[4]);

    assign w_commit     = cfg_commit && !r_busy;
    assign w_commit_ok  = w_commit && w_cfg_ok;
    assign w_commit_bad = w_commit && !w_cfg_ok;
    assign w_fe_active  = frame_end && (r_state != ST_IDLE);

    // Apply immediately when idle or on a frame boundary, else defer to the next one.
    assign w_load = (w_commit_ok && ((r_state == ST_IDLE) || frame_end)) ||
                    (r_busy && w_fe_active);

    assign w_start_err = start && !stop && (r_state == ST_IDLE) && !r_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start && !stop && r_valid) w_state_nxt = ST_RUN;
            ST_RUN:  if (stop) w_state_nxt = ST_STOP;
            ST_STOP: begin
                if (frame_end)             w_state_nxt = ST_IDLE;
                else if (start && !stop)   w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                r_sh_h[i] <= '0;
                r_sh_v[i] <= '0;
            end
        end else if (w_wr_en) begin
            case (cfg_addr)
                4'd0:    r_sh_h[0] <= cfg_wdata[H_BITS-1:0];
                4'd1:    r_sh_h[1] <= cfg_wdata[H_BITS-1:0];
                4'd2:    r_sh_h[2] <= cfg_wdata[H_BITS-1:0];
                4'd3:    r_sh_h[3] <= cfg_wdata[H_BITS-1:0];
                4'd4:    r_sh_h[4] <= cfg_wdata[H_BITS-1:0];
                4'd5:    r_sh_v[0] <= cfg_wdata[V_BITS-1:0];
                4'd6:    r_sh_v[1] <= cfg_wdata[V_BITS-1:0];
                4'd7:    r_sh_v[2] <= cfg_wdata[V_BITS-1:0];
                4'd8:    r_sh_v[3] <= cfg_wdata[V_BITS-1:0];
                default: r_sh_v[4] <= cfg_wdata[V_BITS-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                r_act_h[i] <= '0;
                r_act_v[i] <= '0;
            end
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_valid     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_load) begin
                r_act_h <= r_sh_h;
                r_act_v <= r_sh_v;
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
            end else if (w_commit_ok) begin
                r_busy  <= 1'b1;
            end
            r_err <= w_wr_err || w_commit_bad || w_start_err;
            if (w_fe_active) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign tHS_START   = r_act_h[0];
    assign tHS_END     = r_act_h[1];
    assign tHACT_START = r_act_h[2];
    assign tHACT_END   = r_act_h[3];
    assign tH_END      = r_act_h[4];
    assign tVS_START   = r_act_v[0];
    assign tVS_END     = r_act_v[1];
    assign tVACT_START = r_act_v[2];
    assign tVACT_END   = r_act_v[3];
    assign tV_END      = r_act_v[4];

    assign tpg_en    = (r_state != ST_IDLE);
    assign cfg_busy  = r_busy;
    assign cfg_err   = r_err;
    assign cfg_valid = r_valid;
    assign frame_cnt = r_frame_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// Bench for tpg_timing_ctrl: directed scenarios plus random traffic against a rule-level model.
module tb_tpg_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic        cfg_commit = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        frame_end = 1'b0;

    wire [11:0] a_act  [10];
    wire [11:0] a2_act [10];
    wire        en, busy, err, valid, en2, busy2, err2, valid2;
    wire [15:0] fc;
    wire [1:0]  fc2;
    wire [1:0]  st, st2;

    always #5 clk = ~clk;

    tpg_timing_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .start(start), .stop(stop), .frame_end(frame_end),
        .tHS_START(a_act[0]), .tHS_END(a_act[1]), .tHACT_START(a_act[2]), .tHACT_END(a_act[3]),
        .tH_END(a_act[4]), .tVS_START(a_act[5]), .tVS_END(a_act[6]), .tVACT_START(a_act[7]),
        .tVACT_END(a_act[8]), .tV_END(a_act[9]), .tpg_en(en), .cfg_busy(busy), .cfg_err(err),
        .cfg_valid(valid), .frame_cnt(fc), .state(st)
    );

    tpg_timing_ctrl #(.FC_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .start(start), .stop(stop), .frame_end(frame_end),
        .tHS_START(a2_act[0]), .tHS_END(a2_act[1]), .tHACT_START(a2_act[2]), .tHACT_END(a2_act[3]),
        .tH_END(a2_act[4]), .tVS_START(a2_act[5]), .tVS_END(a2_act[6]), .tVACT_START(a2_act[7]),
        .tVACT_END(a2_act[8]), .tV_END(a2_act[9]), .tpg_en(en2), .cfg_busy(busy2), .cfg_err(err2),
        .cfg_valid(valid2), .frame_cnt(fc2), .state(st2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int good [10] = '{16, 112, 160, 800, 800, 10, 12, 45, 525, 525};

    // Reference model: shadow/active as plain integers, state 0 idle, 1 run, 2 stopping.
    int m_sh [10];
    int m_act[10];
    bit m_busy, m_err, m_valid;
    int m_fc, m_st;

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        m_busy = 0; m_err = 0; m_valid = 0; m_fc = 0; m_st = 0;
    endtask

    task automatic step();
        bit ok, ld, set_busy, e, wr_ok;
        int nst;
        ok = (m_sh[0] < m_sh[1]) && (m_sh[1] <= m_sh[4]) &&
             (m_sh[2] < m_sh[3]) && (m_sh[3] <= m_sh[4]) &&
             (m_sh[5] < m_sh[6]) && (m_sh[6] <= m_sh[9]) &&
             (m_sh[7] < m_sh[8]) && (m_sh[8] <= m_sh[9]);
        ld = 0; set_busy = 0; e = 0; wr_ok = 0;
        if (cfg_commit && !m_busy) begin
            if (!ok)                         e = 1;
            else if (m_st == 0 || frame_end) ld = 1;
            else                             set_busy = 1;
        end
        if (m_busy && frame_end && m_st != 0) ld = 1;
        if (cfg_wr) begin
            if (cfg_addr >= 10 || m_busy) e = 1;
            else                          wr_ok = 1;
        end
        if (start && !stop && m_st == 0 && !m_valid) e = 1;
        nst = m_st;
        if (m_st == 0 && start && !stop && m_valid) nst = 1;
        if (m_st == 1 && stop) nst = 2;
        if (m_st == 2) begin
            if (frame_end)           nst = 0;
            else if (start && !stop) nst = 1;
        end
        if (frame_end && m_st != 0) m_fc++;
        if (ld) begin
            m_act = m_sh; m_valid = 1; m_busy = 0;
        end else if (set_busy) begin
            m_busy = 1;
        end
        if (wr_ok) m_sh[cfg_addr] = int'(cfg_wdata) & 32'hFFF;
        m_err = e;
        m_st  = nst;
        @(posedge clk);
        #1;
        cfg_wr = 0; cfg_commit = 0; start = 0; stop = 0; frame_end = 0;
    endtask

    task automatic reset_dut();
        #2;
        rst_n = 0;
        model_reset();
        #10;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        cfg_wr = 1; cfg_addr = 4'(a); cfg_wdata = 16'(d);
        step();
    endtask

    task automatic load_good();
        for (int i = 0; i < 10; i++) wr(i, good[i]);
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if (en !== 1'b0 || st !== 2'd0 || busy !== 1'b0 || err !== 1'b0 || valid !== 1'b0 ||
            fc !== 16'd0 || a_act[4] !== 12'd0 || a_act[9] !== 12'd0) begin
            n_fail++;
            $display("FAIL reset: en=%0d st=%0d busy=%0d err=%0d valid=%0d fc=%0d hend=%0d vend=%0d, want all 0",
                     en, st, busy, err, valid, fc, a_act[4], a_act[9]);
        end
    endtask

    task automatic test_start_unconfigured();
        start = 1;
        step();
        n_checks++;
        if (err !== 1'b1 || en !== 1'b0 || st !== 2'd0) begin
            n_fail++;
            $display("FAIL start_unconfigured: err=%0d en=%0d st=%0d, want 1 0 0", err, en, st);
        end
        step();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: err=%0d, want 0", err);
        end
    endtask

    task automatic test_idle_commit();
        load_good();
        cfg_commit = 1;
        step();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (a_act[i] !== 12'(good[i])) begin
                n_fail++;
                $display("FAIL idle_commit reg%0d: got %0d, want %0d", i, a_act[i], good[i]);
            end
        end
        n_checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_commit flags: valid=%0d busy=%0d err=%0d, want 1 0 0", valid, busy, err);
        end
        start = 1;
        step();
        n_checks++;
        if (en !== 1'b1 || st !== 2'd1) begin
            n_fail++;
            $display("FAIL start_run: en=%0d st=%0d, want 1 1", en, st);
        end
    endtask

    task automatic test_run_commit();
        int fc0;
        fc0 = m_fc;
        wr(4, 1000);
        cfg_commit = 1;
        step();
        n_checks++;
        if (busy !== 1'b1 || a_act[4] !== 12'd800) begin
            n_fail++;
            $display("FAIL run_commit_pending: busy=%0d hend=%0d, want 1 800", busy, a_act[4]);
        end
        for (int i = 0; i < 3; i++) step();
        frame_end = 1;
        n_checks++;
        if (a_act[4] !== 12'd800) begin
            n_fail++;
            $display("FAIL run_commit_hold: hend=%0d, want 800", a_act[4]);
        end
        step();
        n_checks++;
        if (a_act[4] !== 12'd1000 || busy !== 1'b0 || fc !== 16'(fc0 + 1)) begin
            n_fail++;
            $display("FAIL run_commit_apply: hend=%0d busy=%0d fc=%0d, want 1000 0 %0d",
                     a_act[4], busy, fc, fc0 + 1);
        end
    endtask

    task automatic test_busy_errors();
        wr(4, 900);
        cfg_commit = 1;
        step();
        wr(0, 5);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_write_err: err=%0d busy=%0d, want 1 1", err, busy);
        end
        frame_end = 1;
        step();
        n_checks++;
        if (a_act[0] !== 12'd16 || a_act[4] !== 12'd900) begin
            n_fail++;
            $display("FAIL busy_shadow_frozen: hs_start=%0d hend=%0d, want 16 900", a_act[0], a_act[4]);
        end
        wr(1, 8);
        cfg_commit = 1;
        step();
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || a_act[1] !== 12'd112) begin
            n_fail++;
            $display("FAIL bad_commit: err=%0d busy=%0d hs_end=%0d, want 1 0 112", err, busy, a_act[1]);
        end
        wr(1, 112);
    endtask

    task automatic test_stop();
        stop = 1;
        step();
        for (int i = 0; i < 3; i++) step();
        frame_end = 1;
        n_checks++;
        if (en !== 1'b1 || st !== 2'd2) begin
            n_fail++;
            $display("FAIL stopping: en=%0d st=%0d, want 1 2", en, st);
        end
        step();
        n_checks++;
        if (en !== 1'b0 || st !== 2'd0) begin
            n_fail++;
            $display("FAIL stopped: en=%0d st=%0d, want 0 0", en, st);
        end
    endtask

    task automatic test_stop_cancel();
        start = 1;
        step();
        stop = 1;
        step();
        step();
        start = 1;
        step();
        frame_end = 1;
        step();
        n_checks++;
        if (en !== 1'b1 || st !== 2'd1) begin
            n_fail++;
            $display("FAIL stop_cancel: en=%0d st=%0d, want 1 1", en, st);
        end
        stop = 1;
        start = 1;
        step();
        n_checks++;
        if (st !== 2'd2) begin
            n_fail++;
            $display("FAIL start_stop_same: st=%0d, want 2", st);
        end
    endtask

    task automatic test_fc_wrap();
        reset_dut();
        load_good();
        cfg_commit = 1;
        step();
        frame_end = 1;
        step();
        start = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            frame_end = 1;
            step();
        end
        n_checks++;
        if (fc2 !== 2'd1 || fc !== 16'd5) begin
            n_fail++;
            $display("FAIL fc_wrap: fc2=%0d fc=%0d, want 1 5", fc2, fc);
        end
    endtask

    task automatic test_async_reset();
        wr(4, 700);
        cfg_commit = 1;
        step();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_checks++;
        if (en !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || st !== 2'd0 || fc !== 16'd0 ||
            a_act[4] !== 12'd0 || a_act[0] !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: en=%0d busy=%0d valid=%0d st=%0d fc=%0d hend=%0d, want all 0",
                     en, busy, valid, st, fc, a_act[4]);
        end
        #9;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        reset_dut();
        load_good();
        cfg_commit = 1;
        step();
        for (int c = 0; c < 600; c++) begin
            frame_end = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            start     = !frame_end && ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) begin
                cfg_wr   = 1;
                cfg_addr = 4'($urandom_range(0, 11));
                if ($urandom_range(0, 9) == 0)
                    cfg_wdata = 16'($urandom);
                else if (cfg_addr < 10)
                    cfg_wdata = 16'(good[cfg_addr] + int'($urandom_range(0, 40)) - 20);
                else
                    cfg_wdata = 16'($urandom_range(0, 255));
            end
            cfg_commit = ($urandom_range(0, 7) == 0);
            step();
            n_checks++;
            if (en !== (m_st != 0) || st !== 2'(m_st) || busy !== m_busy || err !== m_err ||
                valid !== m_valid || fc !== 16'(m_fc) || fc2 !== 2'(m_fc) || st2 !== st ||
                en2 !== en || busy2 !== busy || err2 !== err || valid2 !== valid) begin
                n_fail++;
                $display("FAIL random_ctrl cyc%0d: en=%0d st=%0d busy=%0d err=%0d valid=%0d fc=%0d fc2=%0d, want %0d %0d %0d %0d %0d %0d %0d",
                         c, en, st, busy, err, valid, fc, fc2, m_st != 0, m_st, m_busy, m_err,
                         m_valid, m_fc & 16'hFFFF, m_fc & 3);
            end
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (a_act[i] !== 12'(m_act[i]) || a2_act[i] !== 12'(m_act[i])) begin
                    n_fail++;
                    $display("FAIL random_act cyc%0d reg%0d: got %0d/%0d, want %0d",
                             c, i, a_act[i], a2_act[i], m_act[i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start_unconfigured();
        test_idle_commit();
        test_run_commit();
        test_busy_errors();
        test_stop();
        test_stop_cancel();
        test_fc_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tpg_timing_ctrl.md
Name: tpg_timing_ctrl

Overview:
Control block for the video test-pattern generator. It holds a shadow set of the ten horizontal/vertical timing values, loaded through a simple register-write port, and validates them on commit. It applies them atomically to the generator's timing inputs only at a frame boundary, and sequences generator enable with start/stop requests that take effect frame-aligned.

Parameters:
H_BITS, 12, width of horizontal timing values
V_BITS, 12, width of vertical timing values
FC_BITS, 16, width of frame counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_wr  input  1  shadow register write strobe
cfg_addr  input  4  register index (0..9)
cfg_wdata  input  16  write data, LSBs used
cfg_commit  input  1  request to apply shadow set (pulse)
start  input  1  request generator enable (pulse)
stop  input  1  request generator disable (pulse)
frame_end  input  1  one-cycle pulse from generator on last pixel of frame
tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END  output  H_BITS each  active horizontal timing
tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END  output  V_BITS each  active vertical timing
tpg_en  output  1  generator enable
cfg_busy  output  1  commit pending
cfg_err  output  1  one-cycle pulse: rejected write, commit or start
cfg_valid  output  1  active set has been loaded at least once since reset
frame_cnt  output  FC_BITS  frames completed while enabled
state  output  2  0=IDLE, 1=RUN, 2=STOPPING

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: all shadow and active timing regs 0; tpg_en 0; cfg_busy 0; cfg_err 0; cfg_valid 0; frame_cnt 0; state IDLE.
- Address map: 0 HS_START, 1 HS_END, 2 HACT_START, 3 HACT_END, 4 H_END, 5 VS_START, 6 VS_END, 7 VACT_START, 8 VACT_END, 9 V_END.
- Writes: cfg_wdata is truncated to H_BITS/V_BITS and written into the shadow reg; visible internally next cycle.
- Write errors: addr >= 10 is ignored and pulses cfg_err. A write while cfg_busy=1 is dropped and pulses cfg_err; the shadow is frozen while a commit is pending.
- Commit validation: the shadow set is checked combinationally in the commit cycle. Required ordering, unsigned: HS_START < HS_END <= H_END, HACT_START < HACT_END <= H_END, VS_START < VS_END <= V_END, VACT_START < VACT_END <= V_END.
- Invalid commit: cfg_err pulses next cycle; no pending is set; the active set is unchanged.
- Commit while busy: ignored, no error.
- Valid commit in IDLE: the active set loads on that edge; outputs change the next cycle; cfg_valid=1; cfg_busy stays 0.
- Valid commit in RUN or STOPPING: cfg_busy=1 next cycle. The active set loads on the edge where frame_end=1 is sampled, then cfg_busy clears.
- Commit coinciding with frame_end in RUN: applied on that same edge; cfg_busy never asserts.
- Simultaneous cfg_wr and cfg_commit: the commit validates the pre-write shadow; the write lands in the shadow.
- State machine:
  - IDLE: start with cfg_valid=1 -> RUN, tpg_en=1 next cycle. start with cfg_valid=0 -> cfg_err pulse, stay IDLE. stop is ignored.
  - RUN: stop -> STOPPING; start is ignored.
  - STOPPING: tpg_en stays 1; frame_end -> IDLE with tpg_en=0 next cycle; start cancels the stop -> RUN.
  - start and stop in the same cycle: stop wins (IDLE stays IDLE; RUN -> STOPPING).
- frame_cnt: increments on each frame_end sampled in RUN or STOPPING and wraps modulo 2^FC_BITS. It is not cleared by stop; it is cleared only by reset.
- frame_end in IDLE is ignored.
- A pending commit at the frame_end that terminates STOPPING is applied on that edge.
- Reset mid-operation discards any pending commit and forces tpg_en=0 immediately (async).

Test Plan:
- Reset, then start -> cfg_err pulses, tpg_en stays 0, state 0.
- Write 0..9 = {16,112,160,800,800,10,12,45,525,525}, commit in IDLE -> outputs match next cycle, cfg_valid=1; then start -> tpg_en=1, state 1.
- In RUN, write reg4=1000, commit -> cfg_busy=1, tH_END stays 800 until frame_end, becomes 1000 the cycle after, cfg_busy=0, frame_cnt+1.
- While busy, write reg0=5 -> cfg_err pulse, shadow unchanged. Commit with HS_END(1)=8 < HS_START=16 -> cfg_err, active set unchanged.
- stop, 3 cycles idle, frame_end -> tpg_en 1 until frame_end, 0 the next cycle. Repeat with start between stop and frame_end -> stays RUN.
- Set FC_BITS=2, run 5 frames -> frame_cnt=1. Assert rst_n low mid-frame with commit pending -> all outputs 0 asynchronously, cfg_busy=0.
